// File: rtl/mcycle_engine_if.sv
// Request/response bundle between the instruction decoder and the multi-cycle engine.
// The decoder drives the request fields; the engine returns results, Busy and Done.
interface mcycle_engine_if #(parameter int WIDTH = 32);
  logic             Start;
  logic             MCycleOp;
  logic             MCAdd;
  logic             MCLong;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Operand3;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp, MCAdd, MCLong, Operand1, Operand2, Operand3,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, MCAdd, MCLong, Operand1, Operand2, Operand3,
    output Result1, Result2, Busy, Done
  );
endinterface

// File: rtl/mcycle_engine.sv
// Iterative unsigned multiply (shift-add, LSB first) and restoring divide (MSB first),
// one bit per cycle, stalling the execute stage through Busy until Done pulses.
//
// state    | meaning
// IDLE     | waiting for Start; opcode and operands latched on Start
// MUL_ITER | add shifted multiplicand when current multiplier bit is set
// ACC      | add Operand3 to the double-width product (MLA)
// DIV_ITER | trial-subtract divisor, shift in one quotient bit
// DONE     | results just registered, Done high for this one cycle
module mcycle_engine #(
  parameter int WIDTH = 32
) (
  input  logic           CLK,
  input  logic           RESETn,
  mcycle_engine_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] TERM = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_ITER = 3'd1,
    ACC      = 3'd2,
    DIV_ITER = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_add;
  logic                 r_long;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_op3;
  logic [WIDTH-1:0]     r_result1;
  logic [WIDTH-1:0]     r_result2;
  logic                 r_done;

  logic                 w_last;
  logic [2*WIDTH-1:0]   w_mul_nxt;
  logic [2*WIDTH-1:0]   w_acc_sum;
  logic [WIDTH:0]       w_rem_shift;
  logic                 w_rem_ge;
  logic [WIDTH-1:0]     w_rem_sub;
  logic [2*WIDTH-1:0]   w_div_nxt;

  assign w_last    = (r_cnt == TERM);
  assign w_mul_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_acc_sum = r_acc + {{WIDTH{1'b0}}, r_op3};

  // Divide keeps {remainder, dividend/quotient} in r_acc; r_mplier holds the divisor.
  // The shifted remainder is below twice the divisor, so the WIDTH-bit difference is exact.
  assign w_rem_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_rem_ge    = (w_rem_shift >= {1'b0, r_mplier});
  assign w_rem_sub   = w_rem_shift[WIDTH-1:0] - r_mplier;
  assign w_div_nxt   = {(w_rem_ge ? w_rem_sub : w_rem_shift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_rem_ge};

  assign bus.Busy    = ((r_state == IDLE) & bus.Start) | (r_state == MUL_ITER) |
                       (r_state == ACC) | (r_state == DIV_ITER);
  assign bus.Done    = r_done;
  assign bus.Result1 = r_result1;
  assign bus.Result2 = r_result2;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_add     <= 1'b0;
      r_long    <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_op3     <= '0;
      r_result1 <= '0;
      r_result2 <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.Start) begin
            r_add    <= bus.MCAdd;
            r_long   <= bus.MCLong;
            r_mcand  <= {{WIDTH{1'b0}}, bus.Operand1};
            r_mplier <= bus.Operand2;
            r_op3    <= bus.Operand3;
            if (bus.MCycleOp) begin
              r_acc   <= {{WIDTH{1'b0}}, bus.Operand1};
              r_state <= DIV_ITER;
            end else begin
              r_acc   <= '0;
              r_state <= MUL_ITER;
            end
          end
        end

        MUL_ITER: begin
          r_acc    <= w_mul_nxt;
          r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          if (w_last) begin
            if (r_add) begin
              r_state <= ACC;
            end else begin
              r_result1 <= w_mul_nxt[WIDTH-1:0];
              r_result2 <= r_long ? w_mul_nxt[2*WIDTH-1:WIDTH] : '0;
              r_done    <= 1'b1;
              r_state   <= DONE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ACC: begin
          r_acc     <= w_acc_sum;
          r_result1 <= w_acc_sum[WIDTH-1:0];
          r_result2 <= r_long ? w_acc_sum[2*WIDTH-1:WIDTH] : '0;
          r_done    <= 1'b1;
          r_state   <= DONE;
        end

        DIV_ITER: begin
          r_acc <= w_div_nxt;
          if (w_last) begin
            r_result1 <= w_div_nxt[WIDTH-1:0];
            r_result2 <= w_div_nxt[2*WIDTH-1:WIDTH];
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_engine.sv
// Randomized and directed bench for mcycle_engine, checked every cycle against an
// arithmetic reference model that knows only result formulas and cycle latencies.
module tb_mcycle_engine;

  logic CLK = 1'b0;
  logic RESETn;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;

  mcycle_engine_if #(.WIDTH(32)) bus ();

  mcycle_engine #(.WIDTH(32)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit div, input bit add, input bit lng,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    logic [63:0] p;
    if (div) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
    end
    p = {32'd0, a} * {32'd0, b};
    if (add) p = p + {32'd0, c};
    if (!lng) p[63:32] = 32'd0;
    return p;
  endfunction

  // Model: idle flag, cycle index since acceptance, total length to the Done cycle.
  bit          m_idle = 1'b1;
  int          m_cyc = 0;
  int          m_len = 0;
  logic [63:0] m_res = '0;
  logic [63:0] m_pend = '0;

  always @(negedge CLK) begin
    logic e_busy, e_done;
    if (!RESETn) begin
      m_idle = 1'b1;
      m_res  = '0;
      e_busy = bus.Start;
      e_done = 1'b0;
    end else if (m_idle) begin
      e_busy = bus.Start;
      e_done = 1'b0;
    end else if (m_cyc == m_len) begin
      e_busy = 1'b0;
      e_done = 1'b1;
      m_res  = m_pend;
    end else begin
      e_busy = 1'b1;
      e_done = 1'b0;
    end
    if (bus.Done === 1'b1) n_done++;
    chk("cyc_busy", {63'd0, bus.Busy}, {63'd0, e_busy});
    chk("cyc_done", {63'd0, bus.Done}, {63'd0, e_done});
    chk("cyc_result", {bus.Result2, bus.Result1}, m_res);
    if (RESETn) begin
      if (m_idle && bus.Start) begin
        m_pend = model(bus.MCycleOp, bus.MCAdd, bus.MCLong,
                       bus.Operand1, bus.Operand2, bus.Operand3);
        m_len  = (!bus.MCycleOp && bus.MCAdd) ? 34 : 33;
        m_cyc  = 1;
        m_idle = 1'b0;
      end else if (!m_idle) begin
        if (m_cyc == m_len) m_idle = 1'b1;
        else m_cyc++;
      end
    end
  end

  task automatic run_op(input bit op, input bit add, input bit lng,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input bit junk, output int lat);
    bit seen;
    seen = 1'b0;
    @(posedge CLK); #1;
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.MCAdd    = add;
    bus.MCLong   = lng;
    bus.Operand1 = a;
    bus.Operand2 = b;
    bus.Operand3 = c;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      lat++;
      bus.Start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      if (junk) begin
        bus.MCycleOp = 1'($urandom_range(0, 1));
        bus.MCAdd    = 1'($urandom_range(0, 1));
        bus.MCLong   = 1'($urandom_range(0, 1));
        bus.Operand1 = $urandom;
        bus.Operand2 = $urandom;
        bus.Operand3 = $urandom;
      end
      @(negedge CLK);
      if (bus.Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    #1 bus.Start = 1'b0;
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int d0;
    RESETn       = 1'b0;
    bus.Start    = 1'b0;
    bus.MCycleOp = 1'b0;
    bus.MCAdd    = 1'b0;
    bus.MCLong   = 1'b0;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    bus.Operand3 = '0;
    repeat (3) @(posedge CLK);
    #1 RESETn = 1'b1;
    @(negedge CLK);
    chk("rst_r1", {32'd0, bus.Result1}, 64'd0);
    chk("rst_r2", {32'd0, bus.Result2}, 64'd0);
    chk("rst_busy", {63'd0, bus.Busy}, 64'd0);

    run_op(0, 0, 0, 32'd7, 32'd6, 32'd0, 0, lat);
    chk("mul7x6_lat", lat, 33);
    chk("mul7x6_res", {bus.Result2, bus.Result1}, 64'd42);

    run_op(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, lat);
    chk("umull_max", {bus.Result2, bus.Result1}, 64'hFFFF_FFFE_0000_0001);
    run_op(0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, lat);
    chk("mul_max_short", {bus.Result2, bus.Result1}, 64'h0000_0000_0000_0001);

    run_op(0, 1, 0, 32'd3, 32'd4, 32'd5, 0, lat);
    chk("mla_lat", lat, 34);
    chk("mla_res", {bus.Result2, bus.Result1}, 64'd17);
    run_op(0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, lat);
    chk("mla_long", {bus.Result2, bus.Result1}, 64'hFFFF_FFFE_0000_0002);

    run_op(1, 0, 0, 32'd100, 32'd7, 32'd0, 0, lat);
    chk("div_lat", lat, 33);
    chk("div_res", {bus.Result2, bus.Result1}, {32'd2, 32'd14});
    run_op(1, 0, 0, 32'd5, 32'd0, 32'd0, 0, lat);
    chk("div0_res", {bus.Result2, bus.Result1}, {32'd5, 32'hFFFF_FFFF});

    d0 = n_done;
    run_op(1, 0, 0, 32'd100, 32'd7, 32'd0, 1, lat);
    chk("div_junk_res", {bus.Result2, bus.Result1}, {32'd2, 32'd14});
    chk("div_junk_lat", lat, 33);
    chk("div_junk_dones", n_done - d0, 1);

    // Abort a multiply at cycle 10 with reset and confirm nothing leaks out.
    @(posedge CLK); #1;
    bus.Start = 1'b1; bus.MCycleOp = 1'b0; bus.MCAdd = 1'b0; bus.MCLong = 1'b1;
    bus.Operand1 = 32'h1234_5678; bus.Operand2 = 32'h9ABC_DEF0;
    @(posedge CLK); #1 bus.Start = 1'b0;
    repeat (9) @(posedge CLK);
    #1 RESETn = 1'b0;
    @(negedge CLK);
    chk("abort_busy", {63'd0, bus.Busy}, 64'd0);
    chk("abort_res", {bus.Result2, bus.Result1}, 64'd0);
    @(posedge CLK); #1 RESETn = 1'b1;
    d0 = n_done;
    repeat (40) @(posedge CLK);
    chk("abort_no_done", n_done - d0, 0);
    run_op(0, 0, 0, 32'd2, 32'd3, 32'd0, 0, lat);
    chk("post_abort_lat", lat, 33);
    chk("post_abort_res", {bus.Result2, bus.Result1}, 64'd6);

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             pick_operand(), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), lat);
    end

    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
